// File: rtl/id_stage_pkg.sv
// Shared decode constants for the ID stage: opcodes, funct codes, ALU op/sel codes,
// and the decoder-to-stage record.
package id_stage_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;

  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;

  localparam logic [7:0] EXE_NOP_OP = 8'b00000000;
  localparam logic [7:0] EXE_AND_OP = 8'b00100100;
  localparam logic [7:0] EXE_OR_OP  = 8'b00100101;
  localparam logic [7:0] EXE_XOR_OP = 8'b00100110;
  localparam logic [7:0] EXE_NOR_OP = 8'b00100111;
  localparam logic [7:0] EXE_SLL_OP = 8'b01111100;
  localparam logic [7:0] EXE_SRL_OP = 8'b00000010;
  localparam logic [7:0] EXE_SRA_OP = 8'b00000011;

  localparam logic [2:0] EXE_RES_NOP   = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT = 3'b010;

  localparam logic [4:0] NOP_REG_ADDR = 5'd0;

  // Decoder output; register fields are the raw 5-bit instruction fields.
  typedef struct packed {
    logic        invalid;
    logic        wreg;
    logic [4:0]  waddr;
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic        re1;
    logic        re2;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] imm;
  } dec_t;

endpackage

// File: rtl/id_stage_if.sv
// ID stage bus: IF/ID instruction, pipeline control, regfile read ports,
// EX/MEM forwarding sources and the registered ID/EX outputs.
interface id_stage_if #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
);
  logic [31:0]        pc_i;
  logic [31:0]        inst_i;
  logic               inst_valid_i;
  logic               flush_i;
  logic               stall_i;

  logic               reg1_read_o;
  logic               reg2_read_o;
  logic [RADDR_W-1:0] reg1_addr_o;
  logic [RADDR_W-1:0] reg2_addr_o;
  logic [DATA_W-1:0]  reg1_data_i;
  logic [DATA_W-1:0]  reg2_data_i;

  logic               ex_wreg_i;
  logic               ex_is_load_i;
  logic [RADDR_W-1:0] ex_waddr_i;
  logic [DATA_W-1:0]  ex_wdata_i;
  logic               mem_wreg_i;
  logic [RADDR_W-1:0] mem_waddr_i;
  logic [DATA_W-1:0]  mem_wdata_i;

  logic               stallreq_o;

  logic               ex_valid_o;
  logic               ex_wreg_o;
  logic               ex_invalid_o;
  logic [RADDR_W-1:0] ex_waddr_o;
  logic [7:0]         ex_aluop_o;
  logic [2:0]         ex_alusel_o;
  logic [DATA_W-1:0]  ex_reg1_o;
  logic [DATA_W-1:0]  ex_reg2_o;
  logic [31:0]        ex_pc_o;

  modport master (
    output pc_i, inst_i, inst_valid_i, flush_i, stall_i,
    output reg1_data_i, reg2_data_i,
    output ex_wreg_i, ex_is_load_i, ex_waddr_i, ex_wdata_i,
    output mem_wreg_i, mem_waddr_i, mem_wdata_i,
    input  reg1_read_o, reg2_read_o, reg1_addr_o, reg2_addr_o, stallreq_o,
    input  ex_valid_o, ex_wreg_o, ex_invalid_o, ex_waddr_o, ex_aluop_o,
    input  ex_alusel_o, ex_reg1_o, ex_reg2_o, ex_pc_o
  );

  modport slave (
    input  pc_i, inst_i, inst_valid_i, flush_i, stall_i,
    input  reg1_data_i, reg2_data_i,
    input  ex_wreg_i, ex_is_load_i, ex_waddr_i, ex_wdata_i,
    input  mem_wreg_i, mem_waddr_i, mem_wdata_i,
    output reg1_read_o, reg2_read_o, reg1_addr_o, reg2_addr_o, stallreq_o,
    output ex_valid_o, ex_wreg_o, ex_invalid_o, ex_waddr_o, ex_aluop_o,
    output ex_alusel_o, ex_reg1_o, ex_reg2_o, ex_pc_o
  );
endinterface

// File: rtl/id_stage_decode.sv
// Combinational instruction decoder: read/write register selection, immediate
// and ALU op/sel for the supported logic and shift subset.
module id_decode
  import id_stage_pkg::*;
(
  input  logic [31:0] inst_i,
  output dec_t        dec_o
);

  logic [5:0]  op, fn;
  logic [4:0]  rs, rt, rd, sa;
  logic [15:0] imm16;

  assign op    = inst_i[31:26];
  assign rs    = inst_i[25:21];
  assign rt    = inst_i[20:16];
  assign rd    = inst_i[15:11];
  assign sa    = inst_i[10:6];
  assign fn    = inst_i[5:0];
  assign imm16 = inst_i[15:0];

  always_comb begin
    dec_o        = '0;
    dec_o.aluop  = EXE_NOP_OP;
    dec_o.alusel = EXE_RES_NOP;
    // The all-zero word is the canonical NOP: valid, no reads, no write.
    if (inst_i != 32'h0) begin
      case (op)
        OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
          dec_o.re1    = 1'b1;
          dec_o.ra1    = rs;
          dec_o.wreg   = 1'b1;
          dec_o.waddr  = rt;
          dec_o.alusel = EXE_RES_LOGIC;
          dec_o.imm    = {16'h0, imm16};
          case (op)
            OP_ANDI: dec_o.aluop = EXE_AND_OP;
            OP_XORI: dec_o.aluop = EXE_XOR_OP;
            OP_LUI: begin
              dec_o.aluop = EXE_OR_OP;
              dec_o.imm   = {imm16, 16'h0};
            end
            default: dec_o.aluop = EXE_OR_OP;
          endcase
        end
        OP_SPECIAL: begin
          case (fn)
            FN_AND, FN_OR, FN_XOR, FN_NOR: begin
              dec_o.re1    = 1'b1;
              dec_o.ra1    = rs;
              dec_o.re2    = 1'b1;
              dec_o.ra2    = rt;
              dec_o.wreg   = 1'b1;
              dec_o.waddr  = rd;
              dec_o.alusel = EXE_RES_LOGIC;
              case (fn)
                FN_AND:  dec_o.aluop = EXE_AND_OP;
                FN_OR:   dec_o.aluop = EXE_OR_OP;
                FN_XOR:  dec_o.aluop = EXE_XOR_OP;
                default: dec_o.aluop = EXE_NOR_OP;
              endcase
            end
            FN_SLL, FN_SRL, FN_SRA: begin
              // Shift amount rides in operand 1 as an immediate; rt is shifted.
              dec_o.re2    = 1'b1;
              dec_o.ra2    = rt;
              dec_o.wreg   = 1'b1;
              dec_o.waddr  = rd;
              dec_o.alusel = EXE_RES_SHIFT;
              dec_o.imm    = {27'h0, sa};
              case (fn)
                FN_SLL:  dec_o.aluop = EXE_SLL_OP;
                FN_SRL:  dec_o.aluop = EXE_SRL_OP;
                default: dec_o.aluop = EXE_SRA_OP;
              endcase
            end
            default: dec_o.invalid = 1'b1;
          endcase
        end
        default: dec_o.invalid = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/id_stage.sv
// Instruction decode stage: operand fetch with EX/MEM forwarding, load-use
// hazard detection and the ID/EX pipeline register.
module id_stage
  import id_stage_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int FWD_EN  = 1
) (
  input logic       clk,
  input logic       rst,
  id_stage_if.slave bus
);

  typedef struct packed {
    logic               valid;
    logic               wreg;
    logic               invalid;
    logic [RADDR_W-1:0] waddr;
    logic [7:0]         aluop;
    logic [2:0]         alusel;
    logic [DATA_W-1:0]  reg1;
    logic [DATA_W-1:0]  reg2;
    logic [31:0]        pc;
  } idex_t;

  dec_t dec;

  id_decode u_dec (
    .inst_i (bus.inst_i),
    .dec_o  (dec)
  );

  logic                            rd_en;
  logic [1:0]                      re;
  logic [1:0][RADDR_W-1:0]         ra;
  logic [1:0][DATA_W-1:0]          rdata, fwd, opnd;
  logic [1:0]                      ex_hit, mem_hit, load_hit;
  logic                            stallreq;

  assign rd_en    = bus.inst_valid_i & ~rst;
  assign re       = {dec.re2, dec.re1} & {2{rd_en}};
  assign ra[0]    = re[0] ? RADDR_W'(dec.ra1) : '0;
  assign ra[1]    = re[1] ? RADDR_W'(dec.ra2) : '0;
  assign rdata[0] = bus.reg1_data_i;
  assign rdata[1] = bus.reg2_data_i;

  assign bus.reg1_read_o = re[0];
  assign bus.reg2_read_o = re[1];
  assign bus.reg1_addr_o = ra[0];
  assign bus.reg2_addr_o = ra[1];

  // Loads in EX have no data yet, so they never forward; the stall covers them.
  for (genvar gi = 0; gi < 2; gi++) begin : g_opnd
    assign ex_hit[gi]   = (FWD_EN != 0) && bus.ex_wreg_i && !bus.ex_is_load_i &&
                          (bus.ex_waddr_i == ra[gi]);
    assign mem_hit[gi]  = (FWD_EN != 0) && bus.mem_wreg_i && (bus.mem_waddr_i == ra[gi]);
    assign fwd[gi]      = (ra[gi] == '0) ? '0 :
                          ex_hit[gi]     ? bus.ex_wdata_i :
                          mem_hit[gi]    ? bus.mem_wdata_i : rdata[gi];
    assign opnd[gi]     = re[gi] ? fwd[gi] : DATA_W'(dec.imm);
    assign load_hit[gi] = re[gi] && (bus.ex_waddr_i == ra[gi]);
  end

  assign stallreq = (FWD_EN != 0) && bus.inst_valid_i && !rst && bus.ex_is_load_i &&
                    bus.ex_wreg_i && (bus.ex_waddr_i != '0) && (|load_hit);
  assign bus.stallreq_o = stallreq;

  idex_t issue, bubble, idex_d, idex_q;

  always_comb begin
    bubble        = '0;
    bubble.aluop  = EXE_NOP_OP;
    bubble.alusel = EXE_RES_NOP;

    issue         = '0;
    issue.valid   = 1'b1;
    issue.wreg    = dec.wreg;
    issue.invalid = dec.invalid;
    issue.waddr   = RADDR_W'(dec.waddr);
    issue.aluop   = dec.aluop;
    issue.alusel  = dec.alusel;
    issue.reg1    = opnd[0];
    issue.reg2    = opnd[1];
    issue.pc      = bus.pc_i;

    // rst > flush > stall(hold) > load-use bubble > issue
    idex_d = bubble;
    if (!rst && !bus.flush_i) begin
      if (bus.stall_i)                          idex_d = idex_q;
      else if (!stallreq && bus.inst_valid_i)   idex_d = issue;
    end
  end

  always_ff @(posedge clk) begin
    idex_q <= idex_d;
  end

  assign bus.ex_valid_o   = idex_q.valid;
  assign bus.ex_wreg_o    = idex_q.wreg;
  assign bus.ex_invalid_o = idex_q.invalid;
  assign bus.ex_waddr_o   = idex_q.waddr;
  assign bus.ex_aluop_o   = idex_q.aluop;
  assign bus.ex_alusel_o  = idex_q.alusel;
  assign bus.ex_reg1_o    = idex_q.reg1;
  assign bus.ex_reg2_o    = idex_q.reg2;
  assign bus.ex_pc_o      = idex_q.pc;

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 Parameter DATA_W, default 32, datapath and register width.
REQ-002 Parameter RADDR_W, default 5, register-file address width.
REQ-003 Parameter FWD_EN, default 1, enables EX/MEM forwarding; 0 means regfile data only.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 pc_i  in  32 / inst_i  in  32 / inst_valid_i  in  1  instruction from IF/ID.
REQ-007 flush_i  in  1 / stall_i  in  1  pipeline control from ctrl.
REQ-008 reg1_read_o, reg2_read_o  out  1 / reg1_addr_o, reg2_addr_o  out  RADDR_W  regfile read ports; combinational.
REQ-009 reg1_data_i, reg2_data_i  in  DATA_W  regfile read data, same cycle.
REQ-010 ex_wreg_i, ex_is_load_i  in  1 / ex_waddr_i  in  RADDR_W / ex_wdata_i  in  DATA_W  EX-stage result.
REQ-011 mem_wreg_i  in  1 / mem_waddr_i  in  RADDR_W / mem_wdata_i  in  DATA_W  MEM-stage result.
REQ-012 stallreq_o  out  1  load-use stall request; combinational.
REQ-013 ex_valid_o, ex_wreg_o, ex_invalid_o  out  1 / ex_waddr_o  out  RADDR_W / ex_aluop_o  out  8 / ex_alusel_o  out  3 / ex_reg1_o, ex_reg2_o  out  DATA_W / ex_pc_o  out  32  registered ID/EX outputs.

Function
REQ-014 Decoded set: ORI, ANDI, XORI, LUI; SPECIAL AND, OR, XOR, NOR, SLL, SRL, SRA; all-zero word = NOP (SLL $0), valid, wreg 0.
REQ-015 Logic immediates zero-extend inst[15:0]; LUI immediate = {inst[15:0], 16'h0}; shifts use reg1 = zero-extended inst[10:6], reg2 = rt.
REQ-016 I-type: read rs only, write rt; R-type: read rs/rt (shifts rt only), write rd.
REQ-017 Operand with read disabled takes the immediate; read enabled takes forwarded/regfile value.
REQ-018 Operand select priority: address 0 -> 0; EX match (ex_wreg_i, ex_waddr_i equal, not load) -> ex_wdata_i; MEM match -> mem_wdata_i; else regfile.
REQ-019 Unknown opcode/funct: ex_invalid_o 1, ex_wreg_o 0, aluop NOP, ex_valid_o 1.
REQ-020 stallreq_o = inst_valid_i & FWD_EN & ex_is_load_i & ex_wreg_i & ex_waddr_i != 0 & ex_waddr_i matches an enabled read address.
REQ-021 Register update priority per edge: rst > flush_i (bubble) > stall_i (hold all) > stallreq_o (bubble) > load decoded instruction.
REQ-022 Bubble: ex_valid_o 0, ex_wreg_o 0, ex_invalid_o 0, aluop/alusel NOP, operands 0.
REQ-023 inst_valid_i 0 with no higher-priority event loads a bubble.
REQ-024 Latency one cycle from inst_i to ex_* outputs; back-to-back issue at one per cycle.
REQ-025 Simultaneous EX and MEM match to same register: EX wins.
REQ-026 FWD_EN=0: no forwarding, stallreq_o constant 0.

Reset
REQ-027 On rst at clk edge all ex_* outputs 0, aluop EXE_NOP_OP, alusel EXE_RES_NOP; rst mid-stall discards held instruction.
REQ-028 While rst high, read enables and stallreq_o 0.

Structure
REQ-029 Opcodes, funct codes, aluop/alusel codes, NOP address in shared define header.
REQ-030 Combinational decoder in sub-module id_decode; forwarding, hazard and ID/EX register in id_stage.

Verification
REQ-031 ORI $1,$0,0x1100 -> next cycle ex_reg1_o 0, ex_reg2_o 0x00001100, ex_waddr_o 1, ex_wreg_o 1.
REQ-032 OR $3,$1,$2 with ex_waddr_i 1 = 0xAAAA0000 and mem_waddr_i 2 = 0x0000BBBB -> reg1 0xAAAA0000, reg2 0x0000BBBB.
REQ-033 Load to $5 in EX, ANDI $6,$5,0xFF -> stallreq_o 1, next ex_valid_o 0; hazard cleared -> instruction issued.
REQ-034 stall_i held 3 cycles during LUI $7,0x1234 -> ex_reg2_o stays 0x12340000, no change.
REQ-035 flush_i and stall_i same cycle -> bubble; opcode 0x3F -> ex_invalid_o 1, ex_wreg_o 0.
